// File: rtl/score_engine_ser_if.sv
// rtl/score_engine_ser_if.sv - game-side bus of the score engine
// Purpose: groups the line-clear strobe, score controls and score status.
// Signals:
//   hit, lineCount, clear_score, show_high : game core -> engine
//   score, high_score                      : engine -> game core, BCD, 4*DIGITS bits
//   busy, saturated                        : engine -> game core
interface score_engine_ser_if #(
  parameter int DIGITS = 4
);
  logic                hit;
  logic [1:0]          lineCount;
  logic                clear_score;
  logic                show_high;
  logic [4*DIGITS-1:0] score;
  logic [4*DIGITS-1:0] high_score;
  logic                busy;
  logic                saturated;

  modport master (
    output hit, lineCount, clear_score, show_high,
    input  score, high_score, busy, saturated
  );

  modport slave (
    input  hit, lineCount, clear_score, show_high,
    output score, high_score, busy, saturated
  );
endinterface

// File: rtl/score_engine_ser.sv
// rtl/score_engine_ser.sv - BCD Tetris score engine with serial 7-segment output
// Purpose: turns line-clear events into weighted BCD increments (one pending
// event queued), saturates at all-nines, tracks the high score, and shifts a
// 64-bit active-low segment frame MSB first to the serial display chain.
// Ports:
//   clk, rst      : system clock, asynchronous active-high reset
//   bus (slave)   : hit/lineCount/clear_score/show_high in, score/high_score/busy/saturated out
//   SEGCLK        : serial shift clock
//   SEGCLR        : shift-register clear, active low
//   SEGDT         : serial data, MSB first, changes only while SEGCLK is low
//   SEGEN         : display enable
module score_engine_ser #(
  parameter int DIGITS    = 4,
  parameter int SHIFT_DIV = 2,
  parameter int LZ_BLANK  = 1,
  parameter int PTS1      = 1,
  parameter int PTS2      = 3,
  parameter int PTS3      = 5,
  parameter int PTS4      = 8
) (
  input  logic              clk,
  input  logic              rst,
  score_engine_ser_if.slave bus,
  output logic              SEGCLK,
  output logic              SEGCLR,
  output logic              SEGDT,
  output logic              SEGEN
);

  localparam int W  = 4 * DIGITS;
  localparam int DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

  typedef enum logic { A_IDLE, A_ADD }   add_state_t;
  typedef enum logic { S_IDLE, S_SHIFT } sh_state_t;

  add_state_t   a_state, a_next;
  logic [3:0]   remaining, remaining_d, pend_p, pend_p_d, hit_p;
  logic         pend_v, pend_v_d;
  logic [W-1:0] score_q, score_d, high_q;
  logic         sat_q, sat_d;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'h9) r[4*i +: 4] = 4'h0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'h1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  always_comb begin
    case (bus.lineCount)
      2'd0:    hit_p = 4'(PTS1);
      2'd1:    hit_p = 4'(PTS2);
      2'd2:    hit_p = 4'(PTS3);
      default: hit_p = 4'(PTS4);
    endcase
  end

  // ADD is held exactly while remaining != 0, so busy is a plain state decode.
  always_comb begin
    a_next      = a_state;
    remaining_d = remaining;
    pend_v_d    = pend_v;
    pend_p_d    = pend_p;
    score_d     = score_q;
    sat_d       = sat_q;
    if (bus.clear_score) begin
      a_next      = A_IDLE;
      remaining_d = 4'd0;
      pend_v_d    = 1'b0;
      score_d     = '0;
      sat_d       = 1'b0;
    end else begin
      case (a_state)
        A_IDLE: begin
          if (bus.hit) begin
            remaining_d = hit_p;
            a_next      = A_ADD;
          end
        end
        default: begin
          if (score_q != ALL9) score_d = bcd_inc(score_q);
          remaining_d = remaining - 4'd1;
          if (remaining == 4'd1) begin
            // Last unit: chain straight into the queued event (a new hit is
            // dropped if the slot was full) or into a hit arriving right now.
            if (pend_v) begin
              remaining_d = pend_p;
              pend_v_d    = 1'b0;
            end else if (bus.hit) begin
              remaining_d = hit_p;
            end else begin
              a_next = A_IDLE;
            end
          end else if (bus.hit && !pend_v) begin
            pend_v_d = 1'b1;
            pend_p_d = hit_p;
          end
        end
      endcase
      sat_d = sat_q | (score_d == ALL9);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_state   <= A_IDLE;
      remaining <= 4'd0;
      pend_v    <= 1'b0;
      pend_p    <= 4'd0;
      score_q   <= '0;
      high_q    <= '0;
      sat_q     <= 1'b0;
    end else begin
      a_state   <= a_next;
      remaining <= remaining_d;
      pend_v    <= pend_v_d;
      pend_p    <= pend_p_d;
      score_q   <= score_d;
      sat_q     <= sat_d;
      // Packed BCD compares numerically, so a binary max is enough.
      if (score_q > high_q) high_q <= score_q;
    end
  end

  assign bus.score      = score_q;
  assign bus.high_score = high_q;
  assign bus.busy       = (a_state == A_ADD);
  assign bus.saturated  = sat_q;

  logic [W-1:0]  disp;
  logic [31:0]   disp_ext;
  logic [63:0]   frame;
  logic          nz_above;

  // Walk from the top position down; a digit is shown once any digit at or
  // above it is non-zero.
  always_comb begin
    disp     = bus.show_high ? high_q : score_q;
    disp_ext = 32'(disp);
    frame    = '1;
    nz_above = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (k < DIGITS) begin
        nz_above = nz_above | (disp_ext[4*k +: 4] != 4'h0);
        if (nz_above || (k == 0) || (LZ_BLANK == 0))
          frame[8*k +: 8] = seg7(disp_ext[4*k +: 4]);
      end
    end
    if (bus.show_high && (DIGITS < 8)) frame[63:56] = 8'h89;
  end

  sh_state_t     s_state, s_next;
  logic [63:0]   snap, last_frame;
  logic          last_valid, start, div_end, seg_clk_q, en_q;
  logic [5:0]    bit_cnt;
  logic [DW-1:0] div_cnt;

  assign div_end = (div_cnt == DW'(SHIFT_DIV - 1));

  always_comb begin
    s_next = s_state;
    start  = 1'b0;
    case (s_state)
      S_IDLE: begin
        start = !last_valid || (frame != last_frame);
        if (start) s_next = S_SHIFT;
      end
      default: begin
        if (div_end && seg_clk_q && (bit_cnt == 6'd63)) s_next = S_IDLE;
      end
    endcase
  end

  // snap shifts left on each falling SEGCLK, so SEGDT = snap[63] only moves
  // while the clock is low and is all zeros once the frame has gone out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_state    <= S_IDLE;
      snap       <= '0;
      last_frame <= '0;
      last_valid <= 1'b0;
      bit_cnt    <= 6'd0;
      div_cnt    <= '0;
      seg_clk_q  <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      en_q    <= 1'b1;
      s_state <= s_next;
      if (s_state == S_IDLE) begin
        if (start) begin
          snap       <= frame;
          last_frame <= frame;
          last_valid <= 1'b1;
          bit_cnt    <= 6'd0;
          div_cnt    <= '0;
          seg_clk_q  <= 1'b0;
        end
      end else if (div_end) begin
        div_cnt   <= '0;
        seg_clk_q <= ~seg_clk_q;
        if (seg_clk_q) begin
          snap    <= {snap[62:0], 1'b0};
          bit_cnt <= bit_cnt + 6'd1;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  assign SEGCLK = seg_clk_q;
  assign SEGDT  = snap[63];
  assign SEGCLR = en_q;
  assign SEGEN  = en_q;

endmodule

// File: tb/tb_score_engine_ser.sv
// tb/tb_score_engine_ser.sv - directed self-checking bench for score_engine_ser
module tb_score_engine_ser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_engine_ser_if #(.DIGITS(4)) b1 ();
  score_engine_ser_if #(.DIGITS(2)) b2 ();

  logic sclk1, sclr1, sdt1, sen1;
  logic sclk2, sclr2, sdt2, sen2;

  score_engine_ser #(.DIGITS(4)) dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .SEGCLK(sclk1), .SEGCLR(sclr1), .SEGDT(sdt1), .SEGEN(sen1)
  );

  score_engine_ser #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2),
    .SEGCLK(sclk2), .SEGCLR(sclr2), .SEGDT(sdt2), .SEGEN(sen2)
  );

  int          n_run = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          busy1_tot = 0;
  int          busy2_tot = 0;
  int          rx_cnt = 0;
  logic [63:0] rx = '0;
  logic        prev_sclk = 1'b0;
  int          rise_at [0:2047];

  // Serial receiver and busy counters for dut1/dut2, sampled mid-cycle.
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_sclk <= sclk1;
    if (sclk1 && !prev_sclk) begin
      rx                    <= {rx[62:0], sdt1};
      rx_cnt                <= rx_cnt + 1;
      rise_at[rx_cnt[10:0]] <= cyc;
    end
    if (b1.busy) busy1_tot <= busy1_tot + 1;
    if (b2.busy) busy2_tot <= busy2_tot + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hit1(input logic [1:0] lc);
    @(negedge clk);
    b1.hit = 1'b1;
    b1.lineCount = lc;
    @(negedge clk);
    b1.hit = 1'b0;
  endtask

  task automatic hit2(input logic [1:0] lc);
    @(negedge clk);
    b2.hit = 1'b1;
    b2.lineCount = lc;
    @(negedge clk);
    b2.hit = 1'b0;
  endtask

  task automatic wait_idle1();
    int n = 0;
    while (b1.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (b1.busy) check("busy1_timeout", 64'(n), 64'd0);
  endtask

  task automatic wait_idle2();
    int n = 0;
    while (b2.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (b2.busy) check("busy2_timeout", 64'(n), 64'd0);
  endtask

  task automatic wait_rx(input int target);
    int n = 0;
    while (rx_cnt < target && n < 700) begin
      @(posedge clk);
      n++;
    end
    if (rx_cnt < target) check("rx_timeout", 64'(rx_cnt), 64'(target));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int gmin;
    int gmax;
    int g;
    rst = 1'b1;
    b1.hit = 1'b0; b1.lineCount = 2'd0; b1.clear_score = 1'b0; b1.show_high = 1'b0;
    b2.hit = 1'b0; b2.lineCount = 2'd0; b2.clear_score = 1'b0; b2.show_high = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_score", 64'(b1.score), 64'h0);
    check("rst_high", 64'(b1.high_score), 64'h0);
    check("rst_busy", 64'(b1.busy), 64'h0);
    check("rst_sat", 64'(b1.saturated), 64'h0);
    check("rst_segclk", 64'(sclk1), 64'h0);
    check("rst_segdt", 64'(sdt1), 64'h0);
    check("rst_segclr", 64'(sclr1), 64'h0);
    check("rst_segen", 64'(sen1), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("segclr_on", 64'(sclr1), 64'h1);
    check("segen_on", 64'(sen1), 64'h1);

    // 1. first frame after reset shows a lone zero
    wait_rx(64);
    check("frame0", rx, 64'hFFFF_FFFF_FFFF_FFC0);

    // 2. four lines = 8 points, busy exactly 8 cycles, high score one cycle behind
    base = busy1_tot;
    hit1(2'd3);
    check("t2_busy_n", 64'(b1.busy), 64'h1);
    wait_idle1();
    check("t2_score", 64'(b1.score), 64'h0008);
    check("t2_high_lag", 64'(b1.high_score), 64'h0007);
    @(negedge clk);
    check("t2_high", 64'(b1.high_score), 64'h0008);
    @(posedge clk);
    check("t2_busy_cycles", 64'(busy1_tot - base), 64'd8);

    // 3. pending slot chains, third hit dropped
    @(negedge clk); b1.clear_score = 1'b1;
    @(negedge clk); b1.clear_score = 1'b0;
    check("t3_clear_score", 64'(b1.score), 64'h0);
    check("t3_high_kept", 64'(b1.high_score), 64'h0008);
    base = busy1_tot;
    @(negedge clk); b1.hit = 1'b1; b1.lineCount = 2'd1;
    @(negedge clk); b1.hit = 1'b0;
    @(negedge clk); b1.hit = 1'b1; b1.lineCount = 2'd0;
    @(negedge clk); b1.lineCount = 2'd3;
    @(negedge clk); b1.hit = 1'b0;
    check("t3_busy_mid", 64'(b1.busy), 64'h1);
    wait_idle1();
    check("t3_score", 64'(b1.score), 64'h0004);
    @(posedge clk);
    check("t3_busy_cycles", 64'(busy1_tot - base), 64'd4);
    repeat (5) @(negedge clk);
    check("t3_dropped", 64'(b1.score), 64'h0004);

    // 5. hit together with clear_score: clear wins
    @(negedge clk); b1.hit = 1'b1; b1.lineCount = 2'd3; b1.clear_score = 1'b1;
    @(negedge clk); b1.hit = 1'b0; b1.clear_score = 1'b0;
    check("t5_score", 64'(b1.score), 64'h0);
    check("t5_busy", 64'(b1.busy), 64'h0);
    repeat (3) @(negedge clk);
    check("t5_busy_later", 64'(b1.busy), 64'h0);
    check("t5_high", 64'(b1.high_score), 64'h0008);

    // 4. two-digit saturation at 99
    for (int i = 0; i < 12; i++) begin
      hit2(2'd3);
      wait_idle2();
    end
    hit2(2'd0);
    wait_idle2();
    check("t4_score97", 64'(b2.score), 64'h97);
    check("t4_not_sat", 64'(b2.saturated), 64'h0);
    @(posedge clk);
    base = busy2_tot;
    hit2(2'd3);
    wait_idle2();
    check("t4_score99", 64'(b2.score), 64'h99);
    check("t4_sat", 64'(b2.saturated), 64'h1);
    @(posedge clk);
    check("t4_busy_cycles", 64'(busy2_tot - base), 64'd8);
    @(negedge clk); b2.clear_score = 1'b1;
    @(negedge clk); b2.clear_score = 1'b0;
    check("t4_clr_score", 64'(b2.score), 64'h00);
    check("t4_clr_sat", 64'(b2.saturated), 64'h0);
    check("t4_high", 64'(b2.high_score), 64'h99);

    // 6. score 0105 on the serial chain, then the high-score view
    for (int i = 0; i < 13; i++) begin
      hit1(2'd3);
      wait_idle1();
    end
    hit1(2'd0);
    wait_idle1();
    check("t6_score", 64'(b1.score), 64'h0105);
    @(negedge clk);
    check("t6_high", 64'(b1.high_score), 64'h0105);
    repeat (600) @(negedge clk);
    @(posedge clk);
    check("t6_frame_score", rx, 64'hFFFF_FFFF_FFF9_C092);
    check("t6_whole_frames", 64'(rx_cnt % 64), 64'd0);
    base = rx_cnt;
    @(negedge clk); b1.show_high = 1'b1;
    wait_rx(base + 64);
    check("t6_frame_high", rx, 64'h89FF_FFFF_FFF9_C092);
    gmin = 1000;
    gmax = 0;
    for (int i = base + 1; i < base + 64; i++) begin
      g = rise_at[i % 2048] - rise_at[(i - 1) % 2048];
      if (g < gmin) gmin = g;
      if (g > gmax) gmax = g;
    end
    check("t6_gap_min", 64'(gmin), 64'd4);
    check("t6_gap_max", 64'(gmax), 64'd4);
    repeat (300) @(posedge clk);
    check("t6_no_extra_frame", 64'(rx_cnt), 64'(base + 64));
    check("t6_segclk_idle", 64'(sclk1), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/score_engine_ser.md
Name: score_engine_ser

Overview:
Parametrised Tetris score engine with serial 7-segment output. Converts line-clear events into weighted BCD score increments, queues one pending event, saturates at the all-nines value and tracks a live high score. Builds a 64-bit, 8-position active-low segment frame with optional leading-zero blanking and a high-score view. Shifts that frame to the board's serial display chain, sitting between the game core and the SEGCLK/SEGCLR/SEGDT/SEGEN pins.

Parameters:
DIGITS, 4, BCD score digits (1..8); occupy display positions 0..DIGITS-1, position 0 rightmost
SHIFT_DIV, 2, clk cycles per SEGCLK half-period (>=1)
LZ_BLANK, 1, 1 = blank leading zeros (position 0 always shown)
PTS1/PTS2/PTS3/PTS4, 1/3/5/8, points for 1/2/3/4 lines (1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
hit  in  1  one-cycle line-clear strobe
lineCount  in  2  lines cleared minus 1 (0 = 1 line ... 3 = 4 lines); sampled with hit
clear_score  in  1  synchronous score clear (new game); high score kept
show_high  in  1  1 = display high score instead of score
score  out  4*DIGITS  current BCD score
high_score  out  4*DIGITS  BCD high score
busy  out  1  increments outstanding
saturated  out  1  sticky: score hit all-nines
SEGCLK  out  1  serial shift clock
SEGCLR  out  1  shift-register clear, active low
SEGDT  out  1  serial data, MSB first
SEGEN  out  1  display enable

Behaviour:
- Reset (async): score=0, high_score=0, remaining=0, pending empty, busy=0, saturated=0, SEGCLK=0, SEGCLR=0, SEGDT=0, SEGEN=0, last_frame invalid. After reset: SEGCLR=1, SEGEN=1 constant.
- Points P from lineCount per PTSn.
- Adder FSM IDLE/ADD:
  - Hit sampled in IDLE at edge N: remaining=P, busy=1.
  - Each edge with remaining>0: score +1 in BCD with per-digit 9->0 carry, remaining -1.
  - busy = (remaining!=0), registered, so it is high for exactly P cycles.
  - Score is final after edge N+P.
- Hit while busy: stored in a one-deep pending slot (its P). At the edge where remaining goes 1->0, remaining loads the pending P, pending clears and busy stays high. A hit while pending is full is dropped.
- Saturation: at all-nines, increments are no-ops, remaining still counts down, saturated=1 until clear_score.
- clear_score: score=0, remaining=0, pending cleared, saturated=0. It wins over a simultaneous hit, which is dropped.
- High score: at every edge, if score > high_score (BCD vector compare = numeric), high_score <= score (1-cycle lag). On the clear_score edge, high_score <= max(high_score, score).
- Segment code (active low, bit7 = dp, 1 = off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, blank FF, H 89.
- Frame: position k = bits 8k+7:8k.
  - Positions < DIGITS: digit k of the displayed value (score, or high_score if show_high).
  - LZ_BLANK: zero digits above the highest non-zero digit are FF; position 0 is never blanked.
  - Positions >= DIGITS: FF. If show_high and DIGITS<8, position 7 = 89.
- Shifter:
  - Idle with frame != last_frame (or last_frame invalid): snapshot frame, set last_frame.
  - Per bit i=0..63: SEGDT = snap[63-i], SEGCLK low for SHIFT_DIV cycles, then high for SHIFT_DIV cycles. Data is stable across the rising edge.
  - After 64 bits, SEGCLK=0 and return to idle. Frame length = 128*SHIFT_DIV cycles.
  - Frame changes mid-shift are not applied until the next idle check.
- Reset mid-frame or mid-add: immediate return to reset values.

Test Plan:
1. Reset, release -> score=0000, busy=0, SEGCLR=1, SEGEN=1. First frame, DIGITS=4/LZ=1, reads FF×7,C0.
2. hit with lineCount=3 at edge N -> busy high N..N+7, score=0008 after N+8, high_score=0008 one cycle later.
3. hit lineCount=1 then hit lineCount=0 two cycles later -> pending used, busy continuous 4 cycles, score=0004. A third hit while pending is full -> dropped, score stays 0004.
4. DIGITS=2, score 97, hit lineCount=3 -> score 99, saturated=1, busy 8 cycles. clear_score -> score=00, saturated=0, high_score=99.
5. hit + clear_score same edge -> score=0, busy=0.
6. SHIFT_DIV=2, score 0105, LZ=1, show_high=0 -> 64 rising SEGCLK edges, 4 cycles apart, serial bits = FF FF FF FF FF F9 C0 92. show_high=1 with high 0105 -> next frame starts 89 FF FF FF FF F9 C0 92.
